// File: rtl/epsilon_sampler.sv
// LUT-driven random sampler: one Galois LFSR per channel picks a LUT index,
// and a two-stage elastic pipeline emits one sample vector per advance.

module epsilon_sampler_lane #(
  parameter int                IDX_W        = 5,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(1),
  parameter int                CH           = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [IDX_W-1:0]  o_idx
);
  logic [LFSR_W-1:0] r_lfsr;
  logic [IDX_W-1:0]  r_idx;

  // Per-channel decorrelation; a zero state would lock the LFSR, so it maps to 1.
  function automatic logic [LFSR_W-1:0] f_map(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] v;
    v = s ^ LFSR_W'(CH * 32'h0000_9E37);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= f_map(SEED_DEFAULT);
      r_idx  <= '0;
    end else if (i_seed_load) begin
      r_lfsr <= f_map(i_seed);
      r_idx  <= '0;
    end else if (i_advance) begin
      r_idx  <= r_lfsr[IDX_W-1:0];
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    end
  end

  assign o_idx = r_idx;
endmodule

module epsilon_sampler #(
  parameter int                N_CH         = 2,
  parameter int                IDX_W        = 5,
  parameter int                OUT_W        = 20,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_W-1:0]     seed_in,
  input  logic                  seed_load,
  input  logic                  enable,
  input  logic                  lut_we,
  input  logic [IDX_W-1:0]      lut_addr,
  input  logic [OUT_W-1:0]      lut_wdata,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [N_CH*OUT_W-1:0] out_data,
  output logic [N_CH*IDX_W-1:0] out_idx
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [OUT_W-1:0]                r_lut [DEPTH];
  logic [N_CH-1:0][IDX_W-1:0]      w_idx;
  logic [N_CH-1:0][OUT_W-1:0]      r_odata;
  logic [N_CH-1:0][IDX_W-1:0]      r_oidx;
  logic [2:1]                      r_vld_pipe;
  logic                            w_advance;

  assign w_advance = enable & (~r_vld_pipe[2] | out_ready);

  // No reset on the table: contents survive rst. Reads see the pre-write entry.
  always_ff @(posedge clk) begin
    if (lut_we) r_lut[lut_addr] <= lut_wdata;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    epsilon_sampler_lane #(
      .IDX_W(IDX_W), .LFSR_W(LFSR_W), .TAPS(TAPS),
      .SEED_DEFAULT(SEED_DEFAULT), .CH(c)
    ) u_lane (
      .clk(clk), .rst(rst), .i_advance(w_advance), .i_seed_load(seed_load),
      .i_seed(seed_in), .o_idx(w_idx[c])
    );
  end

  // Output slot drains on acceptance even when enable has dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_vld_pipe <= '0;
    else if (seed_load) r_vld_pipe <= '0;
    else if (w_advance) r_vld_pipe <= {r_vld_pipe[1], 1'b1};
    else if (out_ready) r_vld_pipe[2] <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_odata <= '0;
      r_oidx  <= '0;
    end else if (w_advance && !seed_load) begin
      for (int c = 0; c < N_CH; c++) begin
        r_odata[c] <= r_lut[w_idx[c]];
        r_oidx[c]  <= w_idx[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (seed_load) begin
      w_state_nxt = enable ? FILL : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (enable) w_state_nxt = FILL;
        FILL:    if (!enable) w_state_nxt = IDLE;
                 else if (w_advance) w_state_nxt = RUN;
        RUN:     if (!enable) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign out_data  = r_odata;
  assign out_idx   = r_oidx;
endmodule

// File: tb/tb_epsilon_sampler.sv
// Directed bench for epsilon_sampler: hand-computed LFSR/index/data vectors
// covering reset, streaming, backpressure, reseeding, LUT collision and async reset.

module tb_epsilon_sampler;
  localparam int N_CH = 2, IDX_W = 5, OUT_W = 20, LFSR_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LFSR_W-1:0]     seed_in;
  logic                  seed_load, enable, lut_we, out_ready;
  logic [IDX_W-1:0]      lut_addr;
  logic [OUT_W-1:0]      lut_wdata;
  logic                  out_valid;
  logic [N_CH*OUT_W-1:0] out_data;
  logic [N_CH*IDX_W-1:0] out_idx;

  epsilon_sampler #(.N_CH(N_CH), .IDX_W(IDX_W), .OUT_W(OUT_W), .LFSR_W(LFSR_W)) u_dut (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load), .enable(enable),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  wire [LFSR_W-1:0] w_l0 = u_dut.g_lane[0].u_lane.r_lfsr;
  wire [LFSR_W-1:0] w_l1 = u_dut.g_lane[1].u_lane.r_lfsr;
  wire [1:0]        w_st = u_dut.r_state;

  logic [OUT_W-1:0] lut_m [32];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_wr(input logic [IDX_W-1:0] a, input logic [OUT_W-1:0] d);
    lut_we = 1'b1; lut_addr = a; lut_wdata = d;
    tick();
    lut_we = 1'b0;
    lut_m[a] = d;
  endtask

  initial begin
    logic [IDX_W-1:0]  exp_idx [6];
    logic [LFSR_W-1:0] exp_lfsr [6];
    exp_idx  = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h10, 5'h08};
    exp_lfsr = '{16'h0B40, 16'h05A0, 16'h02D0, 16'h0168, 16'h00B4, 16'h005A};

    rst = 1'b1; seed_in = '0; seed_load = 1'b0; enable = 1'b0;
    lut_we = 1'b0; lut_addr = '0; lut_wdata = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_idx",   64'(out_idx),   64'd0);
    chk("rst_lfsr0", 64'(w_l0), 64'h0001);
    chk("rst_lfsr1", 64'(w_l1), 64'h9E36);
    chk("rst_state", 64'(w_st), 64'd0);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) lut_wr(5'(a), '0);
    lut_wr(5'h00, 20'h00E38);
    lut_wr(5'h10, 20'hA5A5A);
    lut_wr(5'h08, 20'h12345);
    lut_wr(5'h14, 20'h0F0F0);
    chk("idle_lfsr0", 64'(w_l0), 64'h0001);

    // Sequence from reset
    enable = 1'b1; out_ready = 1'b1;
    tick();
    chk("e1_valid", 64'(out_valid), 64'd0);
    chk("e1_lfsr0", 64'(w_l0), 64'hB400);
    chk("e1_state", 64'(w_st), 64'd1);
    tick();
    chk("e2_valid", 64'(out_valid), 64'd1);
    chk("e2_idx",   64'(out_idx), 64'h2C1);
    chk("e2_data",  64'(out_data), 64'd0);
    chk("e2_lfsr0", 64'(w_l0), 64'h5A00);
    chk("e2_state", 64'(w_st), 64'd2);
    tick();
    chk("e3_idx0",  64'(out_idx[4:0]), 64'h00);
    chk("e3_data0", 64'(out_data[19:0]), 64'h00E38);
    chk("e3_lfsr0", 64'(w_l0), 64'h2D00);
    tick();
    chk("e4_idx0",  64'(out_idx[4:0]), 64'h00);
    chk("e4_data0", 64'(out_data[19:0]), 64'h00E38);
    chk("e4_lfsr0", 64'(w_l0), 64'h1680);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_idx0",  64'(out_idx[4:0]), 64'h00);
      chk("stall_data0", 64'(out_data[19:0]), 64'h00E38);
      chk("stall_lfsr0", 64'(w_l0), 64'h1680);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("resume_idx0",  64'(out_idx[4:0]), 64'(exp_idx[i]));
      chk("resume_data0", 64'(out_data[19:0]), 64'(lut_m[exp_idx[i]]));
      chk("resume_lfsr0", 64'(w_l0), 64'(exp_lfsr[i]));
    end

    // LUT write collides with the stage-2 read of 0x14
    lut_we = 1'b1; lut_addr = 5'h14; lut_wdata = 20'h77777;
    tick();
    lut_we = 1'b0;
    chk("coll_idx0",  64'(out_idx[4:0]), 64'h14);
    chk("coll_old",   64'(out_data[19:0]), 64'h0F0F0);
    chk("coll_lfsr0", 64'(w_l0), 64'h002D);
    lut_m[5'h14] = 20'h77777;

    // Zero seed
    seed_in = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("zs_valid", 64'(out_valid), 64'd0);
    chk("zs_lfsr0", 64'(w_l0), 64'h0001);
    chk("zs_lfsr1", 64'(w_l1), 64'h9E37);
    tick();
    chk("zs_valid1", 64'(out_valid), 64'd0);
    tick();
    chk("zs_valid2", 64'(out_valid), 64'd1);
    chk("zs_idx",    64'(out_idx), 64'h2E1);
    chk("zs_data0",  64'(out_data[19:0]), 64'd0);

    // Reseed so ch0 re-reads the rewritten entry
    seed_in = 16'h0014; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_lfsr0", 64'(w_l0), 64'h0014);
    chk("rs_lfsr1", 64'(w_l1), 64'h9E23);
    tick();
    tick();
    chk("rs_valid2", 64'(out_valid), 64'd1);
    chk("rs_idx",    64'(out_idx), 64'h074);
    chk("coll_new",  64'(out_data[19:0]), 64'h77777);

    // seed_load with enable falling the same cycle
    seed_in = 16'h1234; seed_load = 1'b1; enable = 1'b0;
    tick();
    seed_load = 1'b0;
    chk("se_valid", 64'(out_valid), 64'd0);
    chk("se_lfsr0", 64'(w_l0), 64'h1234);
    chk("se_lfsr1", 64'(w_l1), 64'h8C03);
    chk("se_state", 64'(w_st), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("se_hold_valid", 64'(out_valid), 64'd0);
      chk("se_hold_lfsr0", 64'(w_l0), 64'h1234);
    end

    // Async reset mid-stream
    enable = 1'b1;
    tick();
    chk("ar_pre_valid", 64'(out_valid), 64'd0);
    chk("ar_pre_lfsr0", 64'(w_l0), 64'h091A);
    tick();
    chk("ar_run_valid", 64'(out_valid), 64'd1);
    chk("ar_run_data0", 64'(out_data[19:0]), 64'h77777);
    #2;
    rst = 1'b1; enable = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_data",  64'(out_data), 64'd0);
    chk("ar_lfsr0", 64'(w_l0), 64'h0001);
    chk("ar_lfsr1", 64'(w_l1), 64'h9E36);
    chk("ar_state", 64'(w_st), 64'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("ar_idle_valid", 64'(out_valid), 64'd0);
    enable = 1'b1;
    tick();
    chk("ar_e1_valid", 64'(out_valid), 64'd0);
    chk("ar_e1_lfsr0", 64'(w_l0), 64'hB400);
    tick();
    chk("ar_e2_valid", 64'(out_valid), 64'd1);
    chk("ar_e2_idx0",  64'(out_idx[4:0]), 64'h01);
    tick();
    chk("ar_lut_kept", 64'(out_data[19:0]), 64'h00E38);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
